vlg_run_ctrl: RTL and testbench

Run sequencer for the vlg_design datapath. After enable it waits a settle interval, then issues RUN_NUM start pulses. Each pulse is followed by a wait for the datapath's done pulse, guarded by a timeout, then an inter-run gap. It reports run count, completion and timeout error, and sits between top-level control and the datapath's start/done handshake.

---
 rtl/vlg_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_vlg_run_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vlg_run_ctrl.sv
// Run sequencer for the vlg_design datapath: settle, then RUN_NUM start/done
// handshakes, each guarded by a timeout and followed by an inter-run gap.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for i_en; counters parked
// WAIT_INIT | settle interval after enable, INIT_WAIT cycles
// START     | single-cycle o_start pulse to the datapath
// WAIT_DONE | waiting for i_done, at most TIMEOUT sampled edges
// GAP       | GAP_CYCLES idle cycles before the next start
// FINISH    | all RUN_NUM runs done; held until i_en drops
// ERROR     | a run timed out; held until i_en drops
`timescale 1ns/1ps

module vlg_run_ctrl #(
  parameter int INIT_WAIT  = 100,
  parameter int TIMEOUT    = 1000,
  parameter int GAP_CYCLES = 16,
  parameter int RUN_NUM    = 16,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic             o_start,
  input  logic             i_done,
  output logic             o_active,
  output logic [CNT_W-1:0] o_run_cnt,
  output logic             o_finish,
  output logic             o_timeout_err
);

  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] RUN_LAST     = CNT_W'(RUN_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam bit               GAP_SKIP     = (GAP_CYCLES == 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    START,
    WAIT_DONE,
    GAP,
    FINISH,
    ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_cnt_d = run_cnt_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_en) begin
          state_d   = WAIT_INIT;
          run_cnt_d = '0;
        end
      end

      WAIT_INIT: begin
        if (!i_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == INIT_LAST) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = i_en ? WAIT_DONE : IDLE;
      end

      // A done on the final timeout edge still counts: done is tested first.
      WAIT_DONE: begin
        if (!i_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (i_done) begin
          run_cnt_d = run_cnt_q + CNT_ONE;
          cnt_d     = '0;
          if (run_cnt_q == RUN_LAST)
            state_d = FINISH;
          else
            state_d = GAP_SKIP ? START : GAP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      GAP: begin
        if (!i_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      FINISH, ERROR: begin
        cnt_d = '0;
        if (!i_en) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_start       = (state_q == START);
  assign o_active      = (state_q == WAIT_INIT) || (state_q == START) ||
                         (state_q == WAIT_DONE) || (state_q == GAP);
  assign o_finish      = (state_q == FINISH);
  assign o_timeout_err = (state_q == ERROR);
  assign o_run_cnt     = run_cnt_q;

endmodule

// File: tb/tb_vlg_run_ctrl.sv
// Bench for vlg_run_ctrl: directed and randomized sequences checked against an
// event-time model (start/done/end edges computed arithmetically per sequence).
`timescale 1ns/1ps

module tb_vlg_run_ctrl;

  localparam int INIT_WAIT  = 100;
  localparam int TIMEOUT    = 50;
  localparam int GAP_CYCLES = 4;
  localparam int RUN_NUM    = 3;
  localparam int CNT_W      = 16;
  localparam int K_ABORT    = 0;
  localparam int K_RESET    = 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_en;
  logic             i_done;
  logic             o_start;
  logic             o_active;
  logic [CNT_W-1:0] o_run_cnt;
  logic             o_finish;
  logic             o_timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model: edge offsets from E0 (the edge that samples i_en high)
  int m_s[RUN_NUM];
  int m_dn[RUN_NUM];
  int m_pulse[RUN_NUM];
  int m_win[RUN_NUM];
  int m_nstarts;
  int m_end;
  bit m_fin;

  always #5 i_clk = ~i_clk;

  vlg_run_ctrl #(
    .INIT_WAIT(INIT_WAIT), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES),
    .RUN_NUM(RUN_NUM), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .o_start(o_start),
    .i_done(i_done), .o_active(o_active), .o_run_cnt(o_run_cnt),
    .o_finish(o_finish), .o_timeout_err(o_timeout_err)
  );

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, want);
    end
  endtask

  task automatic chk_all(input int t, input logic s, input logic a, input logic f,
                         input logic e, input int cnt);
    chk("start",   t, {31'b0, o_start},       {31'b0, s});
    chk("active",  t, {31'b0, o_active},      {31'b0, a});
    chk("finish",  t, {31'b0, o_finish},      {31'b0, f});
    chk("timeout", t, {31'b0, o_timeout_err}, {31'b0, e});
    chk("run_cnt", t, {16'b0, o_run_cnt},     cnt);
  endtask

  // d = edges after WAIT_DONE entry at which done arrives; 0 = never.
  task automatic build_model(input int d0, input int d1, input int d2);
    int d[RUN_NUM];
    int t0;
    d = '{d0, d1, d2};
    t0 = INIT_WAIT;
    m_fin = 1'b0;
    m_end = 0;
    m_nstarts = 0;
    for (int k = 0; k < RUN_NUM; k++) begin
      m_s[k] = -1; m_dn[k] = -1; m_pulse[k] = -1; m_win[k] = 0;
    end
    for (int k = 0; k < RUN_NUM; k++) begin
      m_s[k] = t0;
      m_nstarts = k + 1;
      if (d[k] > 0) m_pulse[k] = t0 + 1 + d[k];
      if (d[k] >= 1 && d[k] <= TIMEOUT) begin
        m_dn[k]  = t0 + 1 + d[k];
        m_win[k] = d[k];
        if (k == RUN_NUM - 1) begin
          m_end = m_dn[k];
          m_fin = 1'b1;
        end else begin
          t0 = m_dn[k] + GAP_CYCLES;
        end
      end else begin
        m_win[k] = TIMEOUT;
        m_end = t0 + 1 + TIMEOUT;
        break;
      end
    end
  endtask

  function automatic bit is_start(input int t);
    for (int k = 0; k < m_nstarts; k++) if (m_s[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit sched(input int t);
    for (int k = 0; k < m_nstarts; k++) if (m_pulse[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_cnt(input int t);
    int c = 0;
    for (int k = 0; k < m_nstarts; k++) if (m_dn[k] >= 0 && m_dn[k] <= t) c++;
    return c;
  endfunction

  // Stray done pulses only on edges where the sequencer is not awaiting a done.
  function automatic bit stray_ok(input int t);
    if (t < 1) return 1'b0;
    for (int k = 0; k < m_nstarts; k++)
      if (t > m_s[k] + 1 && t <= m_s[k] + 1 + m_win[k]) return 1'b0;
    return !sched(t);
  endfunction

  // stop_req > 0: stop at that edge; 0: natural end + 5; < 0: random stop edge.
  task automatic run_seq(input int d0, input int d1, input int d2,
                         input int stop_req, input int kind, input bit strays);
    int stop_t;
    int held;
    build_model(d0, d1, d2);
    if (stop_req > 0)      stop_t = stop_req;
    else if (stop_req < 0) stop_t = int'($urandom_range(1, m_end + 3));
    else                   stop_t = m_end + 5;
    i_en = 1'b1;
    i_done = 1'b0;
    @(posedge i_clk);
    for (int t = 0; t < stop_t; t++) begin
      #1;
      chk_all(t, is_start(t), t < m_end, m_fin && t >= m_end, !m_fin && t >= m_end, exp_cnt(t));
      if (t + 1 == stop_t) begin
        if (kind == K_RESET) i_rst_n = 1'b0;
        else                 i_en = 1'b0;
      end
      i_done = sched(t + 1) || (strays && stray_ok(t + 1) && ($urandom_range(0, 7) == 0));
      @(posedge i_clk);
    end
    #1;
    i_done = 1'b0;
    held = (kind == K_RESET) ? 0 : exp_cnt(stop_t - 1);
    chk_all(stop_t, 1'b0, 1'b0, 1'b0, 1'b0, held);
    if (kind == K_RESET) begin
      i_rst_n = 1'b1;
    end else begin
      @(posedge i_clk);
      #1;
      chk_all(stop_t + 1, 1'b0, 1'b0, 1'b0, 1'b0, held);
    end
  endtask

  function automatic int pick_d();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return TIMEOUT + 1 + int'($urandom_range(0, 5));
    if (r == 1) return TIMEOUT;
    if (r == 2) return 1;
    return int'($urandom_range(1, TIMEOUT));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t observed=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    i_en = 1'b0;
    i_done = 1'b0;

    // Reset held, then idle with stray done pulses
    repeat (100) @(posedge i_clk);
    #1;
    chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    i_rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      i_done = ($urandom_range(0, 3) == 0);
      @(posedge i_clk);
      #1;
      chk_all(-2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    i_done = 1'b0;

    // Normal sequence, done 10 edges after each WAIT_DONE entry
    run_seq(10, 10, 10, 0, K_ABORT, 1'b0);
    // Timeout on first run
    run_seq(0, 0, 0, 0, K_ABORT, 1'b0);
    // Done exactly on the last allowed edge, then one edge too late
    run_seq(TIMEOUT, TIMEOUT + 1, 10, 0, K_ABORT, 1'b0);
    // Reset during WAIT_DONE of run 2, then restart with i_en held
    run_seq(10, 10, 10, INIT_WAIT + 20, K_RESET, 1'b0);
    run_seq(10, 10, 10, 0, K_ABORT, 1'b1);
    // Abort in GAP after run 1, then a full re-run
    run_seq(10, 10, 10, INIT_WAIT + 13, K_ABORT, 1'b0);
    run_seq(10, 10, 10, 0, K_ABORT, 1'b1);

    // Randomized sequences
    for (int i = 0; i < 8; i++) begin
      int a, b, c, st, kd;
      a = pick_d(); b = pick_d(); c = pick_d();
      st = ($urandom_range(0, 2) == 0) ? -1 : 0;
      kd = ($urandom_range(0, 1) == 0) ? K_ABORT : K_RESET;
      run_seq(a, b, c, st, (st < 0) ? kd : K_ABORT, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
